// File: rtl/rtp_pkg.sv
// rtp_pkg: shared types and constants for the RTP result writer slice.
//   hit_rec_t   - per-ray hit record {ray_id, hit_t, tri_idx}
//   MISS_T      - IEEE-754 +inf, the hit distance reported for a miss
//   res_state_e - result writer run state
package rtp_pkg;

  typedef struct packed {
    logic [31:0] ray_id;
    logic [31:0] hit_t;
    logic [31:0] tri_idx;  // triangle index ("tri" is a reserved word)
  } hit_rec_t;

  localparam logic [31:0] MISS_T = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } res_state_e;

  function automatic logic is_miss(input hit_rec_t rec);
    return rec.hit_t == MISS_T;
  endfunction

endpackage

// File: rtl/rtp_result_writer_if.sv
// rtp_result_writer_if: hit-record input handshake plus result RAM write port.
//   io_hit_valid/io_hit_ready         - record handshake
//   io_hit_ray_id/io_hit_t/io_hit_tri - record fields
//   io_res_wr_en/io_res_wr_ready      - RAM write handshake
//   io_res_wr_addr/io_res_wr_data     - RAM write address / {tri, hitT}
// Modports: master = record producer and RAM model, slave = result writer.
interface rtp_result_writer_if #(
  parameter int ADDR_W = 10
);

  logic              io_hit_valid;
  logic              io_hit_ready;
  logic [31:0]       io_hit_ray_id;
  logic [31:0]       io_hit_t;
  logic [31:0]       io_hit_tri;
  logic              io_res_wr_en;
  logic              io_res_wr_ready;
  logic [ADDR_W-1:0] io_res_wr_addr;
  logic [63:0]       io_res_wr_data;

  modport master (
    output io_hit_valid, io_hit_ray_id, io_hit_t, io_hit_tri,
    input  io_hit_ready,
    input  io_res_wr_en, io_res_wr_addr, io_res_wr_data,
    output io_res_wr_ready
  );

  modport slave (
    input  io_hit_valid, io_hit_ray_id, io_hit_t, io_hit_tri,
    output io_hit_ready,
    output io_res_wr_en, io_res_wr_addr, io_res_wr_data,
    input  io_res_wr_ready
  );

endinterface

// File: rtl/rtp_result_fifo.sv
// rtp_result_fifo: registered synchronous FIFO of hit_rec_t, no bypass.
//   clock, reset (async active-low)
//   clr       - synchronous flush
//   push/push_data, pop - writes are ignored when full, reads when empty
//   head      - oldest entry (valid when !empty)
//   full, empty
// DEPTH must be a power of two >= 2.
module rtp_result_fifo
  import rtp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     clr,
  input  logic     push,
  input  hit_rec_t push_data,
  input  logic     pop,
  output hit_rec_t head,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);

  hit_rec_t      mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = count == (PW+1)'(DEPTH);
    empty   = count == '0;
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (do_pop && !do_push) count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/rtp_result_writer.sv
// rtp_result_writer: result-side endpoint of the ray-tracing pipeline.
// Buffers hit records, writes them to the result RAM, counts retired rays and
// reports run status.
//   clock, reset (async active-low), io_start (run start pulse)
//   bus                - rtp_result_writer_if.slave (hit input + RAM write)
//   io_hitT            - hitT of the last retired record
//   io_ray_id_triangle - triangle of the last retired record
//   io_rtp_finish      - high while the run is complete
//   io_counter_cycles  - number of RUN cycles of the current/last run
//   io_err_cnt         - dropped out-of-range records (saturating)
// Optional feature: define RTP_RESULT_MISS_FILTER_EN to retire miss records
// (hitT == +inf) without writing them to the RAM.
module rtp_result_writer
  import rtp_pkg::*;
#(
  parameter int RAY_NUM    = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_start,
  rtp_result_writer_if.slave  bus,
  output logic [31:0]         io_hitT,
  output logic [31:0]         io_ray_id_triangle,
  output logic                io_rtp_finish,
  output logic [63:0]         io_counter_cycles,
  output logic [15:0]         io_err_cnt
);

  localparam int            CW      = ADDR_W + 1;
  localparam logic [CW-1:0] RAY_CNT = CW'(RAY_NUM);

  res_state_e    state;
  logic [CW-1:0] acc_cnt;
  logic [CW-1:0] ret_cnt;

  hit_rec_t push_rec;
  hit_rec_t head;
  logic     full;
  logic     empty;
  logic     hit_ready;
  logic     accept;
  logic     in_range;
  logic     push;
  logic     drop;
  logic     wr_en;
  logic     retire;
  logic     clr;

  always_comb begin
    hit_ready = (state == ST_RUN) && !full && (acc_cnt < RAY_CNT);
    accept    = bus.io_hit_valid && hit_ready;
    in_range  = bus.io_hit_ray_id < 32'(RAY_NUM);
    push      = accept && in_range;
    drop      = accept && !in_range;
    push_rec  = '{ray_id: bus.io_hit_ray_id, hit_t: bus.io_hit_t, tri_idx: bus.io_hit_tri};
    clr       = io_start && (state != ST_RUN);
`ifdef RTP_RESULT_MISS_FILTER_EN
    // A miss at the head leaves in one cycle without touching the RAM.
    wr_en  = !empty && !is_miss(head);
    retire = (wr_en && bus.io_res_wr_ready) || (!empty && is_miss(head));
`else
    wr_en  = !empty;
    retire = wr_en && bus.io_res_wr_ready;
`endif
  end

  // Only in-range ids are ever pushed, so the head's full id stays in range.
  always_comb begin
    if (!empty) assert (head.ray_id < 32'(RAY_NUM));
  end

  assign bus.io_hit_ready   = hit_ready;
  assign bus.io_res_wr_en   = wr_en;
  assign bus.io_res_wr_addr = head.ray_id[ADDR_W-1:0];
  assign bus.io_res_wr_data = {head.tri_idx, head.hit_t};

  rtp_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clr       (clr),
    .push      (push),
    .push_data (push_rec),
    .pop       (retire),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // The cycle counter is loaded with 1 on the start edge and skips the
  // increment on the edge into DONE, so it reads k during the k-th RUN cycle
  // and ends at exactly the number of RUN cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      acc_cnt            <= '0;
      ret_cnt            <= '0;
      io_hitT            <= '0;
      io_ray_id_triangle <= '0;
      io_rtp_finish      <= 1'b0;
      io_counter_cycles  <= '0;
      io_err_cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (io_start) begin
            state             <= ST_RUN;
            acc_cnt           <= '0;
            ret_cnt           <= '0;
            io_err_cnt        <= '0;
            io_counter_cycles <= 64'd1;
            io_rtp_finish     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (push) acc_cnt <= acc_cnt + CW'(1);
          if (drop && io_err_cnt != '1) io_err_cnt <= io_err_cnt + 16'd1;
          if (retire) begin
            ret_cnt            <= ret_cnt + CW'(1);
            io_hitT            <= head.hit_t;
            io_ray_id_triangle <= head.tri_idx;
          end
          if (retire && (ret_cnt + CW'(1) == RAY_CNT)) begin
            state         <= ST_DONE;
            io_rtp_finish <= 1'b1;
          end else begin
            io_counter_cycles <= io_counter_cycles + 64'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtp_result_writer.sv
// tb_rtp_result_writer: scoreboard bench for rtp_result_writer.
// Drivers push expected RAM writes when a record is accepted; a monitor pops
// and compares on every RAM write. Run-level status is checked at finish.
// Honors RTP_RESULT_MISS_FILTER_EN the same way as the design.
module tb_rtp_result_writer;
  import rtp_pkg::*;

  localparam int RAY_NUM    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 4;
`ifdef RTP_RESULT_MISS_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_start = 1'b0;
  logic [31:0] io_hitT;
  logic [31:0] io_ray_id_triangle;
  logic        io_rtp_finish;
  logic [63:0] io_counter_cycles;
  logic [15:0] io_err_cnt;

  rtp_result_writer_if #(.ADDR_W(ADDR_W)) bus ();

  rtp_result_writer #(
    .RAY_NUM    (RAY_NUM),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_start           (io_start),
    .bus                (bus),
    .io_hitT            (io_hitT),
    .io_ray_id_triangle (io_ray_id_triangle),
    .io_rtp_finish      (io_rtp_finish),
    .io_counter_cycles  (io_counter_cycles),
    .io_err_cnt         (io_err_cnt)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } wr_t;
  wr_t         exp_q[$];
  int          err_model;
  logic [31:0] last_t;
  logic [31:0] last_tri;
  bit          last_write;
  int unsigned last_write_cyc;

  // Monitor
  bit                rdy_rand = 1'b0;
  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev;
  logic [63:0]       data_prev;

  always @(negedge clock) begin
    wr_t e;
    if (reset && bus.io_res_wr_en) begin
      if (stall_prev) begin
        chk("stall_addr_stable", bus.io_res_wr_addr, addr_prev);
        chk("stall_data_stable", bus.io_res_wr_data, data_prev);
      end
      if (FILT) chk("filtered_miss_written", bus.io_res_wr_data[31:0] == MISS_T, 0);
      if (bus.io_res_wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.io_res_wr_addr, e.addr);
          chk("wr_data", bus.io_res_wr_data, e.data);
        end
        last_write_cyc = cyc;
      end
    end
    stall_prev = reset && bus.io_res_wr_en && !bus.io_res_wr_ready;
    addr_prev  = bus.io_res_wr_addr;
    data_prev  = bus.io_res_wr_data;
  end

  always @(posedge clock) begin
    #1;
    if (rdy_rand) bus.io_res_wr_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [31:0] rand_t(input bit allow_miss);
    logic [31:0] v;
    v = $urandom;
    if (v == MISS_T) v = 32'h3F80_0000;
    if (allow_miss && $urandom_range(0, 5) == 0) v = MISS_T;
    return v;
  endfunction

  // Call with inputs changing away from the edge; returns after the accepting
  // edge (+1 time unit). waits = cycles spent with ready low.
  task automatic send(input logic [31:0] id, input logic [31:0] t, input logic [31:0] tr,
                      output int waits);
    bus.io_hit_ray_id = id;
    bus.io_hit_t      = t;
    bus.io_hit_tri    = tr;
    bus.io_hit_valid  = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge clock);
      if (bus.io_hit_ready) break;
      waits++;
      if (waits > 300) begin
        chk("send_timeout", 1, 0);
        bus.io_hit_valid = 1'b0;
        return;
      end
    end
    @(posedge clock);
    #1;
    bus.io_hit_valid = 1'b0;
    if (id < RAY_NUM) begin
      last_t     = t;
      last_tri   = tr;
      last_write = !(FILT && t == MISS_T);
      if (last_write) exp_q.push_back('{addr: id[ADDR_W-1:0], data: {tr, t}});
    end else begin
      err_model++;
    end
  endtask

  task automatic do_start(output int unsigned s);
    @(posedge clock);
    #1;
    io_start = 1'b1;
    @(posedge clock);
    #1;
    io_start  = 1'b0;
    s         = cyc;
    err_model = 0;
    exp_q.delete();
    chk("start_finish_clear", io_rtp_finish, 0);
    chk("start_cycles_first", io_counter_cycles, 1);
    chk("start_err_clear", io_err_cnt, 0);
  endtask

  task automatic finish_check(input int unsigned s);
    int unsigned f;
    int w;
    w = 0;
    do begin
      @(negedge clock);
      w++;
      if (w > 3000) begin
        chk("finish_timeout", 1, 0);
        return;
      end
    end while (!io_rtp_finish);
    f = cyc;
    chk("run_cycles", io_counter_cycles, 64'(f - s));
    chk("all_writes_seen", exp_q.size(), 0);
    chk("err_cnt", io_err_cnt, err_model);
    chk("last_hitT", io_hitT, last_t);
    chk("last_triangle", io_ray_id_triangle, last_tri);
    if (last_write) chk("finish_after_last_retire", f - last_write_cyc, 1);
    repeat (4) @(negedge clock);
    chk("cycles_frozen", io_counter_cycles, 64'(f - s));
    chk("finish_sticky", io_rtp_finish, 1);
    chk("ready_low_done", bus.io_hit_ready, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hit_ready"}, bus.io_hit_ready, 0);
    chk({tag, "_wr_en"}, bus.io_res_wr_en, 0);
    chk({tag, "_wr_addr"}, bus.io_res_wr_addr, 0);
    chk({tag, "_wr_data"}, bus.io_res_wr_data, 0);
    chk({tag, "_hitT"}, io_hitT, 0);
    chk({tag, "_triangle"}, io_ray_id_triangle, 0);
    chk({tag, "_finish"}, io_rtp_finish, 0);
    chk({tag, "_cycles"}, io_counter_cycles, 0);
    chk({tag, "_err"}, io_err_cnt, 0);
  endtask

  task automatic run_random();
    int unsigned s;
    int n_in;
    int w;
    int g;
    logic [31:0] id;
    do_start(s);
    n_in = 0;
    while (n_in < RAY_NUM) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clock);
        #1;
      end
      if ($urandom_range(0, 7) == 0) begin
        id = ($urandom_range(0, 1) == 0) ? 32'(RAY_NUM + $urandom_range(0, 1000)) : 32'hFFFF_FFF0;
      end else begin
        id = $urandom_range(0, RAY_NUM - 1);
        n_in++;
      end
      send(id, rand_t(1'b1), $urandom, w);
    end
    finish_check(s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned s;
    int w;
    bus.io_hit_valid    = 1'b0;
    bus.io_hit_ray_id   = '0;
    bus.io_hit_t        = '0;
    bus.io_hit_tri      = '0;
    bus.io_res_wr_ready = 1'b1;
    err_model  = 0;
    last_write = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // Directed run: ids 0..RAY_NUM-1, RAM always ready
    do_start(s);
    for (int i = 0; i < RAY_NUM; i++) send(i, rand_t(1'b0), $urandom, w);
    finish_check(s);

    // Backpressure: FIFO fills to depth, ready drops, then drains 1/cycle
    do_start(s);
    bus.io_res_wr_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      send(i, rand_t(1'b0), $urandom, w);
      chk("bp_accept_no_wait", w, 0);
    end
    bus.io_hit_ray_id = FIFO_DEPTH;
    bus.io_hit_t      = rand_t(1'b0);
    bus.io_hit_tri    = $urandom;
    bus.io_hit_valid  = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("full_ready_low", bus.io_hit_ready, 0);
    end
    @(posedge clock);
    #1;
    bus.io_res_wr_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          @(negedge clock);
          chk("drain_per_cycle", bus.io_res_wr_en && bus.io_res_wr_ready, 1);
        end
      end
      begin
        send(bus.io_hit_ray_id, bus.io_hit_t, bus.io_hit_tri, w);
        for (int i = FIFO_DEPTH + 1; i < RAY_NUM; i++) send(i, rand_t(1'b0), $urandom, w);
      end
    join
    finish_check(s);

    // Out-of-range id and a miss record
    do_start(s);
    rdy_rand = 1'b1;
    for (int i = 0; i < 3; i++) send(i, rand_t(1'b0), $urandom, w);
    send(RAY_NUM + 5, rand_t(1'b0), $urandom, w);
    send(3, MISS_T, 32'h0000_0ABC, w);
    for (int i = 4; i < RAY_NUM; i++) send(i, rand_t(1'b0), $urandom, w);
    finish_check(s);

    // Reset mid-run with records still buffered
    rdy_rand = 1'b0;
    bus.io_res_wr_ready = 1'b0;
    do_start(s);
    send(0, rand_t(1'b0), $urandom, w);
    send(1, rand_t(1'b0), $urandom, w);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midrun_reset");
    exp_q.delete();
    repeat (2) @(negedge clock);
    check_zero("held_reset");
    reset = 1'b1;
    bus.io_res_wr_ready = 1'b1;
    rdy_rand = 1'b1;
    run_random();

    // Back-to-back randomized runs restarted from DONE
    for (int r = 0; r < 3; r++) run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
